// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - captures one pixel tile and streams every WIN x WIN window of it
module conv_window_sequencer #(
    parameter int PIX_W  = 4,
    parameter int TILE   = 4,
    parameter int WIN    = 3,
    parameter int STRIDE = 1,
    localparam int NPOS  = (TILE - WIN) / STRIDE + 1,
    localparam int IDX_W = (NPOS > 1) ? $clog2(NPOS) : 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        tile_valid,
    output logic                        tile_ready,
    input  logic [TILE*TILE*PIX_W-1:0]  tile_pixels,
    input  logic                        abort,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [WIN*WIN*PIX_W-1:0]    win_pixels,
    output logic [IDX_W-1:0]            win_row,
    output logic [IDX_W-1:0]            win_col,
    output logic                        win_last,
    output logic [15:0]                 tile_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPOS - 1);

    state_t                       state, state_nxt;
    logic [TILE*TILE*PIX_W-1:0]   tile_q;
    logic [IDX_W-1:0]             row_q, col_q, row_nxt, col_nxt;
    logic [15:0]                  cnt_q, cnt_nxt;
    logic                         load;
    logic                         last_pos;

    assign last_pos = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    // Abort only matters while streaming; in IDLE the block behaves as if abort were low.
    always_comb begin
        state_nxt  = state;
        row_nxt    = row_q;
        col_nxt    = col_q;
        cnt_nxt    = cnt_q;
        load       = 1'b0;
        tile_ready = 1'b0;
        case (state)
            IDLE: begin
                tile_ready = 1'b1;
                if (tile_valid) begin
                    load      = 1'b1;
                    state_nxt = STREAM;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            STREAM: begin
                tile_ready = last_pos & win_ready & ~abort;
                if (abort) begin
                    state_nxt = IDLE;
                    row_nxt   = '0;
                    col_nxt   = '0;
                end else if (win_ready) begin
                    if (last_pos) begin
                        cnt_nxt = cnt_q + 16'd1;
                        row_nxt = '0;
                        col_nxt = '0;
                        if (tile_valid) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (col_q == LAST_IDX) begin
                        col_nxt = '0;
                        row_nxt = row_q + IDX_W'(1);
                    end else begin
                        col_nxt = col_q + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            tile_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            row_q <= row_nxt;
            col_q <= col_nxt;
            cnt_q <= cnt_nxt;
            if (load) begin
                tile_q <= tile_pixels;
            end
        end
    end

    // Window is a pure function of the stored tile and the position counters.
    always_comb begin
        win_pixels = '0;
        if (state == STREAM) begin
            for (int i = 0; i < WIN; i++) begin
                for (int j = 0; j < WIN; j++) begin
                    win_pixels[(i*WIN+j)*PIX_W +: PIX_W] =
                        tile_q[((int'(row_q)*STRIDE + i)*TILE + int'(col_q)*STRIDE + j)*PIX_W +: PIX_W];
                end
            end
        end
    end

    assign win_valid  = (state == STREAM);
    assign win_row    = win_valid ? row_q : '0;
    assign win_col    = win_valid ? col_q : '0;
    assign win_last   = win_valid & last_pos;
    assign tile_count = cnt_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - randomized and directed checks of conv_window_sequencer against a window-index model
module tb_conv_window_sequencer;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic tv = 1'b0, ab = 1'b0, wr = 1'b0;
    logic [7:0] tp [25];
    int sel = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Three configurations: defaults, TILE5/WIN3/STRIDE2 with 5-bit pixels, TILE3/WIN3.
    int cfg_t [3] = '{4, 5, 3};
    int cfg_w [3] = '{3, 3, 3};
    int cfg_s [3] = '{1, 2, 1};
    int cfg_p [3] = '{4, 5, 4};

    logic [63:0]  tp0;
    logic [124:0] tp1;
    logic [35:0]  tp2;
    always_comb begin
        tp0 = '0;
        tp1 = '0;
        tp2 = '0;
        for (int i = 0; i < 16; i++) tp0[i*4 +: 4] = tp[i][3:0];
        for (int i = 0; i < 25; i++) tp1[i*5 +: 5] = tp[i][4:0];
        for (int i = 0; i < 9; i++)  tp2[i*4 +: 4] = tp[i][3:0];
    end

    logic        rdy0, rdy1, rdy2, wv0, wv1, wv2, wl0, wl1, wl2;
    logic [35:0] wp0, wp2;
    logic [44:0] wp1;
    logic [0:0]  row0, row1, row2, col0, col1, col2;
    logic [15:0] cnt0, cnt1, cnt2;

    conv_window_sequencer u0 (
        .clk(clk), .n_rst(n_rst), .tile_valid(tv), .tile_ready(rdy0), .tile_pixels(tp0),
        .abort(ab), .win_valid(wv0), .win_ready(wr), .win_pixels(wp0), .win_row(row0),
        .win_col(col0), .win_last(wl0), .tile_count(cnt0));

    conv_window_sequencer #(.PIX_W(5), .TILE(5), .WIN(3), .STRIDE(2)) u1 (
        .clk(clk), .n_rst(n_rst), .tile_valid(tv), .tile_ready(rdy1), .tile_pixels(tp1),
        .abort(ab), .win_valid(wv1), .win_ready(wr), .win_pixels(wp1), .win_row(row1),
        .win_col(col1), .win_last(wl1), .tile_count(cnt1));

    conv_window_sequencer #(.PIX_W(4), .TILE(3), .WIN(3), .STRIDE(1)) u2 (
        .clk(clk), .n_rst(n_rst), .tile_valid(tv), .tile_ready(rdy2), .tile_pixels(tp2),
        .abort(ab), .win_valid(wv2), .win_ready(wr), .win_pixels(wp2), .win_row(row2),
        .win_col(col2), .win_last(wl2), .tile_count(cnt2));

    logic         o_rdy, o_valid, o_last;
    logic [127:0] o_pix;
    logic [0:0]   o_row, o_col;
    logic [15:0]  o_cnt;
    always_comb begin
        o_rdy = rdy0; o_valid = wv0; o_last = wl0; o_pix = 128'(wp0);
        o_row = row0; o_col = col0; o_cnt = cnt0;
        if (sel == 1) begin
            o_rdy = rdy1; o_valid = wv1; o_last = wl1; o_pix = 128'(wp1);
            o_row = row1; o_col = col1; o_cnt = cnt1;
        end else if (sel == 2) begin
            o_rdy = rdy2; o_valid = wv2; o_last = wl2; o_pix = 128'(wp2);
            o_row = row2; o_col = col2; o_cnt = cnt2;
        end
    end

    // Reference model: busy flag, linear window index k, copy of the tile, tile counter.
    int mt, mw, ms, mp, np;
    bit m_busy;
    int m_k;
    int m_mem [25];
    int m_cnt;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_pix();
        logic [127:0] res;
        int r, c, v;
        res = '0;
        if (m_busy) begin
            r = m_k / np;
            c = m_k % np;
            for (int i = 0; i < mw; i++)
                for (int j = 0; j < mw; j++) begin
                    v = m_mem[(r*ms + i)*mt + c*ms + j];
                    res = res | (128'(v) << ((i*mw + j)*mp));
                end
        end
        return res;
    endfunction

    function automatic bit m_last();
        return m_busy && (m_k == np*np - 1);
    endfunction

    task automatic check_all(input string tag);
        bit exp_rdy;
        exp_rdy = !m_busy || (m_last() && wr && !ab);
        chk({tag, "_valid"}, o_valid, m_busy);
        chk({tag, "_ready"}, o_rdy, exp_rdy);
        chk({tag, "_pix"},   o_pix, exp_pix());
        chk({tag, "_row"},   o_row, m_busy ? (m_k / np) : 0);
        chk({tag, "_col"},   o_col, m_busy ? (m_k % np) : 0);
        chk({tag, "_last"},  o_last, m_last());
        chk({tag, "_cnt"},   o_cnt, m_cnt);
    endtask

    task automatic load_model();
        for (int i = 0; i < mt*mt; i++) m_mem[i] = int'(tp[i]) & ((1 << mp) - 1);
    endtask

    task automatic drive_in(input logic v, input logic a, input logic r, input string tag);
        tv = v; ab = a; wr = r;
        #1;
        check_all(tag);
    endtask

    task automatic adv();
        if (!m_busy) begin
            if (tv) begin load_model(); m_busy = 1; m_k = 0; end
        end else if (ab) begin
            m_busy = 0; m_k = 0;
        end else if (wr) begin
            if (m_last()) begin
                m_cnt = (m_cnt + 1) & 16'hffff;
                m_k = 0;
                if (tv) load_model();
                else m_busy = 0;
            end else begin
                m_k++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        n_rst = 1'b0; tv = 1'b0; ab = 1'b0; wr = 1'b0;
        #1;
        m_busy = 0; m_k = 0; m_cnt = 0;
        for (int i = 0; i < 25; i++) m_mem[i] = 0;
        check_all("rst");
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic use_cfg(input int s);
        sel = s;
        mt = cfg_t[s]; mw = cfg_w[s]; ms = cfg_s[s]; mp = cfg_p[s];
        np = (mt - mw) / ms + 1;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 25; i++) tp[i] = 8'd0;
        for (int r = 0; r < mt; r++)
            for (int c = 0; c < mt; c++) begin
                if (mode == 0)      tp[r*mt + c] = 8'(r*mt + c);
                else if (mode == 1) tp[r*mt + c] = 8'(15 - (r*mt + c));
                else                tp[r*mt + c] = 8'($urandom);
            end
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            fill(2);
            drive_in($urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 3) != 0, "rnd");
            adv();
        end
    endtask

    int tl5 [4] = '{0, 2, 10, 12};
    int v5 [9]  = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    logic [127:0] e5;

    initial begin
        for (int i = 0; i < 25; i++) tp[i] = 8'd0;
        use_cfg(0);
        @(negedge clk);
        do_reset();

        // Straight-through tile, full-rate consumer.
        fill(0);
        drive_in(1, 0, 1, "t1a"); chk("t1_rdy", o_rdy, 1); adv();
        drive_in(0, 0, 1, "t1");  chk("t1_w0", o_pix, 128'h0A98654210); adv();
        drive_in(0, 0, 1, "t1");  chk("t1_tl1", o_pix[3:0], 1); adv();
        drive_in(0, 0, 1, "t1");  chk("t1_tl2", o_pix[3:0], 4); adv();
        drive_in(0, 0, 1, "t1");  chk("t1_tl3", o_pix[3:0], 5); chk("t1_last", o_last, 1); adv();
        drive_in(0, 0, 1, "t1");  chk("t1_idle", o_valid, 0); chk("t1_cnt", o_cnt, 1); adv();

        // Backpressure at window (0,1).
        drive_in(1, 0, 1, "t2"); adv();
        drive_in(0, 0, 1, "t2"); adv();
        for (int i = 0; i < 3; i++) begin
            drive_in(0, 0, 0, "t2h");
            chk("t2_hold_tl", o_pix[3:0], 1); chk("t2_hold_col", o_col, 1);
            adv();
        end
        drive_in(0, 0, 1, "t2");  chk("t2_rel_tl", o_pix[3:0], 1); adv();
        drive_in(0, 0, 1, "t2");  chk("t2_next_tl", o_pix[3:0], 4); chk("t2_next_row", o_row, 1); adv();
        drive_in(0, 0, 1, "t2");  adv();
        drive_in(0, 0, 1, "t2");  chk("t2_done", o_valid, 0); chk("t2_cnt", o_cnt, 2); adv();

        // Back-to-back tiles with no idle cycle.
        do_reset();
        fill(0);
        drive_in(1, 0, 1, "t3"); adv();
        for (int i = 0; i < 3; i++) begin drive_in(0, 0, 1, "t3"); adv(); end
        fill(1);
        drive_in(1, 0, 1, "t3b"); chk("t3_rdy", o_rdy, 1); adv();
        drive_in(0, 0, 1, "t3b"); chk("t3_b_valid", o_valid, 1); chk("t3_b_tl", o_pix[3:0], 15);
        chk("t3_cnt1", o_cnt, 1); adv();
        for (int i = 0; i < 3; i++) begin drive_in(0, 0, 1, "t3b"); adv(); end
        drive_in(0, 0, 1, "t3e"); chk("t3_cnt2", o_cnt, 2); adv();

        // Abort at (1,0) with a tile offered, then async reset mid-stream.
        drive_in(1, 0, 1, "t4"); adv();
        drive_in(0, 0, 1, "t4"); adv();
        drive_in(0, 0, 1, "t4"); adv();
        drive_in(1, 1, 1, "t4a"); chk("t4_rdy", o_rdy, 0); chk("t4_row", o_row, 1); adv();
        drive_in(0, 0, 1, "t4b"); chk("t4_idle", o_valid, 0); chk("t4_cnt", o_cnt, 2); adv();
        drive_in(1, 0, 1, "t4"); adv();
        drive_in(0, 0, 0, "t4"); adv();
        do_reset();
        chk("t4_rst_cnt", o_cnt, 0);
        random_run(300);

        // TILE=5, WIN=3, STRIDE=2.
        use_cfg(1);
        do_reset();
        fill(0);
        e5 = '0;
        for (int k = 0; k < 9; k++) e5 = e5 | (128'(v5[k]) << (k*5));
        drive_in(1, 0, 1, "t5"); adv();
        for (int k = 0; k < 4; k++) begin
            drive_in(0, 0, 1, "t5");
            chk("t5_tl", o_pix[4:0], tl5[k]);
            if (k == 3) begin chk("t5_pix11", o_pix, e5); chk("t5_last", o_last, 1); end
            adv();
        end
        drive_in(0, 0, 1, "t5e"); chk("t5_cnt", o_cnt, 1); adv();
        random_run(300);

        // TILE=WIN: one window per tile.
        use_cfg(2);
        do_reset();
        fill(2);
        drive_in(1, 0, 1, "t6"); adv();
        drive_in(0, 0, 1, "t6");
        chk("t6_last", o_last, 1); chk("t6_row", o_row, 0); chk("t6_col", o_col, 0);
        adv();
        drive_in(0, 0, 1, "t6e"); chk("t6_idle", o_valid, 0); adv();
        random_run(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
